turtle_clock_control: RTL and testbench

- Board-facing clock/reset front end; sits directly upstream of the CPU core inside turtle_cpu_top.
- Conditions raw reset_btn, manual_clk_sw and pulse_clk_btn into a stretched core reset and a single-cycle core clock enable.
- The core advances only on cycles where cpu_clk_en=1. Enables come from a free-running divider in auto mode, or one per debounced button press in manual mode.

---
 rtl/turtle_clock_control.sv | 86 ++++++++
 tb/tb_turtle_clock_control.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/turtle_clock_control.sv
// turtle_clock_control: debounced reset/mode/step inputs into a stretched core reset and single-cycle core clock enable
module turtle_clock_control #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DIV        = 4,
  parameter int RESET_HOLD      = 16,
  parameter int STEP_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_btn,
  input  logic              manual_clk_sw,
  input  logic              pulse_clk_btn,
  output logic              cpu_reset_n,
  output logic              cpu_clk_en,
  output logic              manual_mode,
  output logic [STEP_W-1:0] step_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int DW = AUTO_DIV > 1 ? $clog2(AUTO_DIV) : 1;
  localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
  localparam logic [1:0] RST_ASSERT = 2'd0, RST_HOLD = 2'd1, RUN = 2'd2;
  logic [2:0]        w_raw, r_s1, r_s2, r_deb;
  logic [CW-1:0]     r_cnt [3];
  logic [1:0]        r_state, w_next;
  logic [HW-1:0]     r_hold;
  logic [DW-1:0]     r_div;
  logic              r_mm_d, r_pb_d, r_en, r_rst_n;
  logic              w_rbtn, w_pb, w_run, w_mode_chg, w_rise, w_en;
  logic [STEP_W-1:0] r_step;
  assign w_raw = {pulse_clk_btn, manual_clk_sw, reset_btn};
  // two-flop synchronizers for all raw board inputs
  always_ff @(posedge clk)
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  // debounce: debounced value follows only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk)
    for (int d = 0; d < 3; d++)
      if (reset) begin
        r_cnt[d] <= '0;
        r_deb[d] <= 1'b0;
      end else if (r_s2[d] == r_deb[d]) r_cnt[d] <= '0;
      else if (r_cnt[d] == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb[d] <= r_s2[d];
        r_cnt[d] <= '0;
      end else r_cnt[d] <= r_cnt[d] + 1'b1;
  assign w_rbtn      = r_deb[0];
  assign manual_mode = r_deb[1];
  assign w_pb        = r_deb[2];
  assign w_next = w_rbtn ? RST_ASSERT :
                  r_state == RST_ASSERT ? RST_HOLD :
                  r_state == RST_HOLD ? (r_hold == HW'(RESET_HOLD - 1) ? RUN : RST_HOLD) :
                  r_state == RUN ? RUN : RST_ASSERT;
  assign w_run      = (r_state == RUN) && (w_next == RUN);
  assign w_mode_chg = manual_mode ^ r_mm_d;
  assign w_rise     = w_pb & ~r_pb_d;
  assign w_en       = w_run & ~w_mode_chg & (manual_mode ? w_rise : r_div == DW'(AUTO_DIV - 1));
  // reset sequencer, divider, edge history and registered outputs
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= RST_ASSERT;
      r_hold  <= '0;
      r_div   <= '0;
      r_mm_d  <= 1'b0;
      r_pb_d  <= 1'b0;
      r_en    <= 1'b0;
      r_rst_n <= 1'b0;
      r_step  <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= r_state == RST_HOLD ? r_hold + 1'b1 : '0;
      r_div   <= (r_state != RUN || manual_mode || w_mode_chg || r_div == DW'(AUTO_DIV - 1)) ? '0 : r_div + 1'b1;
      r_mm_d  <= manual_mode;
      r_pb_d  <= w_pb;
      r_en    <= w_en;
      r_rst_n <= w_next == RUN;
      r_step  <= w_next != RUN ? '0 : r_step + STEP_W'(w_en);
    end
  assign cpu_reset_n = r_rst_n;
  assign cpu_clk_en  = r_en;
  assign step_count  = r_step;
endmodule

// File: tb/tb_turtle_clock_control.sv
// tb_turtle_clock_control: directed checks of reset stretch, auto/manual stepping, debounce and wrap
module tb_turtle_clock_control;
  logic clk = 1'b0;
  logic rst = 1'b1, rbtn = 1'b0, msw = 1'b0, pbtn = 1'b0;
  logic rn, en, mm;
  logic [15:0] sc;
  logic rst6 = 1'b1, rbtn6 = 1'b0, msw6 = 1'b0, pbtn6 = 1'b0;
  logic rn6, en6, mm6;
  logic [3:0] sc6;
  int checks = 0, errors = 0;
  logic [15:0] s0;
  turtle_clock_control #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(3), .RESET_HOLD(5), .STEP_W(16)) u_dut (
    .clk(clk), .reset(rst), .reset_btn(rbtn), .manual_clk_sw(msw), .pulse_clk_btn(pbtn),
    .cpu_reset_n(rn), .cpu_clk_en(en), .manual_mode(mm), .step_count(sc));
  turtle_clock_control #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(1), .RESET_HOLD(5), .STEP_W(4)) u_dut6 (
    .clk(clk), .reset(rst6), .reset_btn(rbtn6), .manual_clk_sw(msw6), .pulse_clk_btn(pbtn6),
    .cpu_reset_n(rn6), .cpu_clk_en(en6), .manual_mode(mm6), .step_count(sc6));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    tick(3);
    checks++;
    if ({rn, en, mm} !== 3'b000 || sc !== 16'd0) begin
      errors++;
      $display("FAIL reset_state rn=%b en=%b mm=%b sc=%0d required 0 0 0 0", rn, en, mm, sc);
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if (rn !== 1'b0) begin errors++; $display("FAIL rst_hold rn=%b required 0", rn); end
    tick(1);
    checks++;
    if (rn !== 1'b1) begin errors++; $display("FAIL rst_release rn=%b required 1", rn); end
  endtask
  task automatic test_auto;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      checks++;
      if (en !== (i % 3 == 0)) begin errors++; $display("FAIL auto_en cycle %0d en=%b required %b", i, en, i % 3 == 0); end
    end
    checks++;
    if (sc !== 16'd4) begin errors++; $display("FAIL auto_count sc=%0d required 4", sc); end
  endtask
  task automatic test_manual;
    msw = 1'b1;
    tick(5);
    checks++;
    if (mm !== 1'b0) begin errors++; $display("FAIL mode_early mm=%b required 0", mm); end
    tick(1);
    checks++;
    if (mm !== 1'b1) begin errors++; $display("FAIL mode_rise mm=%b required 1", mm); end
    tick(1);
    s0 = sc;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (en !== 1'b0) begin errors++; $display("FAIL manual_no_auto en=%b required 0", en); end
    end
    pbtn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (en !== (i == 7)) begin errors++; $display("FAIL manual_step cycle %0d en=%b required %b", i, en, i == 7); end
    end
    pbtn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (en !== 1'b0) begin errors++; $display("FAIL manual_release en=%b required 0", en); end
    end
    checks++;
    if (sc !== s0 + 16'd1) begin errors++; $display("FAIL manual_count sc=%0d required %0d", sc, s0 + 16'd1); end
  endtask
  task automatic test_glitch;
    s0 = sc;
    pbtn = 1'b1;
    tick(3);
    pbtn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++;
      if (en !== 1'b0) begin errors++; $display("FAIL glitch_en en=%b required 0", en); end
    end
    checks++;
    if (sc !== s0) begin errors++; $display("FAIL glitch_count sc=%0d required %0d", sc, s0); end
    pbtn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checks++;
      if (en !== (i == 7)) begin errors++; $display("FAIL post_glitch cycle %0d en=%b required %b", i, en, i == 7); end
    end
    pbtn = 1'b0;
    tick(8);
  endtask
  task automatic test_reset_btn;
    rbtn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checks++;
      if (rn !== (i < 7)) begin errors++; $display("FAIL rbtn_press cycle %0d rn=%b required %b", i, rn, i < 7); end
      if (i >= 7) begin
        checks++;
        if (sc !== 16'd0 || en !== 1'b0) begin errors++; $display("FAIL rbtn_clear sc=%0d en=%b required 0 0", sc, en); end
      end
    end
    rbtn = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      checks++;
      if (rn !== (i == 12) || en !== 1'b0) begin errors++; $display("FAIL rbtn_release cycle %0d rn=%b en=%b required %b 0", i, rn, en, i == 12); end
    end
  endtask
  task automatic test_pulse_in_reset;
    rbtn = 1'b1;
    tick(7);
    checks++;
    if (rn !== 1'b0) begin errors++; $display("FAIL pir_reset rn=%b required 0", rn); end
    pbtn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 3) rbtn = 1'b0;
      checks++;
      if (en !== 1'b0) begin errors++; $display("FAIL pir_held cycle %0d en=%b required 0", i, en); end
    end
    checks++;
    if (rn !== 1'b1) begin errors++; $display("FAIL pir_run rn=%b required 1", rn); end
    pbtn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++;
      if (en !== 1'b0) begin errors++; $display("FAIL pir_release en=%b required 0", en); end
    end
    pbtn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checks++;
      if (en !== (i == 7)) begin errors++; $display("FAIL pir_fresh cycle %0d en=%b required %b", i, en, i == 7); end
    end
    pbtn = 1'b0;
    checks++;
    if (sc !== 16'd1) begin errors++; $display("FAIL pir_count sc=%0d required 1", sc); end
  endtask
  task automatic test_wrap;
    logic [3:0] e;
    rst6 = 1'b0;
    tick(5);
    checks++;
    if (rn6 !== 1'b0) begin errors++; $display("FAIL wrap_hold rn=%b required 0", rn6); end
    tick(1);
    checks++;
    if (rn6 !== 1'b1 || sc6 !== 4'd0) begin errors++; $display("FAIL wrap_run rn=%b sc=%0d required 1 0", rn6, sc6); end
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      e = i[3:0];
      checks++;
      if (en6 !== 1'b1 || sc6 !== e) begin errors++; $display("FAIL wrap_step %0d en=%b sc=%0d required 1 %0d", i, en6, sc6, e); end
    end
  endtask
  initial begin
    test_reset;
    test_auto;
    test_manual;
    test_glitch;
    test_reset_btn;
    test_pulse_in_reset;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
